button_debouncer: RTL and testbench

Input conditioning stage for the registered data path. Takes a raw, asynchronous, bouncing push-button or switch and synchronises it to `clk`. It filters out bounce and produces a clean level, plus one-cycle press and release pulses. Its outputs drive the D inputs of the downstream flip-flop and register stages, so those stages only ever see glitch-free, clock-aligned data.

---
 rtl/button_debouncer.sv | 99 +++++++++
 tb/tb_button_debouncer.sv | 107 ++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser plus debounce FSM with press/release pulses (DEBOUNCE_LONG_PRESS_EN adds btn_long)
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int LONG_CYCLES   = 50000000,
  parameter int LONG_W        = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  output logic btn_long
`endif
);
  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(STABLE_CYCLES) ||
      (64'd1 << LONG_W) <= 64'(LONG_CYCLES)) begin : g_bad_params
    $error("button_debouncer: illegal parameter combination");
  end
  state_e state_q, state_d;
  logic sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      S_LOW:  if (sync2_q) begin
        state_d = S_RISE;
        cnt_d   = CNT_W'(1);
      end
      S_RISE: if (!sync2_q) state_d = S_LOW;
        else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      S_HIGH: if (!sync2_q) begin
        state_d = S_FALL;
        cnt_d   = CNT_W'(1);
      end
      S_FALL: if (sync2_q) state_d = S_HIGH;
        else if (cnt_q == LAST) begin
          state_d   = S_LOW;
          release_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
    endcase
    level_d = state_d == S_HIGH || state_d == S_FALL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  logic [LONG_W-1:0] long_q, long_d;
  logic long_pulse_q, long_pulse_d;
  // level_q mirrors "state is S_HIGH or S_FALL"; saturation makes the pulse fire once per press
  always_comb begin
    long_d       = state_d == S_LOW ? '0 :
                   (level_q && long_q != LONG_MAX) ? long_q + LONG_W'(1) : long_q;
    long_pulse_d = long_d == LONG_MAX && long_q != LONG_MAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q       <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_pulse_q <= long_pulse_d;
    end
  end
  assign btn_long = long_pulse_q;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed table-driven bench for button_debouncer with STABLE_CYCLES=4, LONG_CYCLES=10
module tb_button_debouncer;
  logic clk, rst_n, btn_raw, btn_level, btn_press, btn_release;
  int checks = 0, errors = 0;
  typedef struct {
    logic       raw;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[$];
`ifdef DEBOUNCE_LONG_PRESS_EN
  logic btn_long;
`endif
  button_debouncer #(.STABLE_CYCLES(4), .CNT_W(3), .LONG_CYCLES(10), .LONG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
`ifdef DEBOUNCE_LONG_PRESS_EN
    , .btn_long(btn_long)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [2:0] outs();
    return {btn_level, btn_press, btn_release};
  endfunction
  task automatic add(input logic raw, input logic [2:0] exp, input int n);
    for (int k = 0; k < n; k++) tbl.push_back('{raw, exp});
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
`ifdef DEBOUNCE_LONG_PRESS_EN
  task automatic long_press(input string name);
    int pc = -1, lc = -1, nl = 0;
    btn_raw = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (btn_press) pc = c;
      if (btn_long) begin
        nl++;
        lc = c;
      end
    end
    chk({name, "_long_count"}, nl, 1);
    chk({name, "_long_delay"}, lc - pc, 10);
    btn_raw = 1'b0;
    repeat (10) step();
  endtask
`endif
  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    // clean press: level/press after E5, press gone after E6
    add(1'b1, 3'b000, 5); add(1'b1, 3'b110, 1); add(1'b1, 3'b100, 2);
    // clean release
    add(1'b0, 3'b100, 5); add(1'b0, 3'b001, 1); add(1'b0, 3'b000, 2);
    // bounce 1,0,1,0 every two cycles
    add(1'b1, 3'b000, 2); add(1'b0, 3'b000, 2); add(1'b1, 3'b000, 2); add(1'b0, 3'b000, 6);
    // sync2 drops on the edge the count would complete: bounce wins
    add(1'b1, 3'b000, 3); add(1'b0, 3'b000, 4);
    // exactly STABLE_CYCLES high is accepted, then released
    add(1'b1, 3'b000, 4); add(1'b0, 3'b000, 1); add(1'b0, 3'b110, 1);
    add(1'b0, 3'b100, 3); add(1'b0, 3'b001, 1); add(1'b0, 3'b000, 1);
    #12;
    chk("reset_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      btn_raw = tbl[i].raw;
      step();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    btn_raw = 1'b1;
    repeat (6) step();
    chk("pre_async_press", outs(), 3'b110);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("midcount_before_rst", outs(), 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midcount_in_rst", outs(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("midcount_after_E%0d", i), outs(), i == 5 ? 3'b110 : 3'b000);
    end
    btn_raw = 1'b0;
    repeat (8) step();
    chk("final_low", outs(), 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
    long_press("lp1");
    long_press("lp2");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
